// File: rtl/game_pkg.sv
// Shared game types and scan codes for the frame-rate game sequencer.
// No logic; pure declarations.
// Backpressure: not applicable.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    DELAY = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } game_state_t;

  localparam logic [7:0] KEY_START   = 8'h16;
  localparam logic [7:0] KEY_RESTART = 8'h15;

endpackage

// File: rtl/brick_clear_fifo.sv
// Small synchronous FIFO with flush; head data is shown combinationally from the storage flops.
// Latency: a push becomes visible at the head the cycle after it is written.
// Backpressure: push ignored when full (full judged before any same-cycle pop); pop ignored when empty.
module brick_clear_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: serve/play/life-loss/end sequencing, lives and brick counts, brick-clear queue.
// Latency: every output is registered, one frame after the sampled inputs.
// Backpressure: clears wait on clr_ready; hits arriving while the queue is full are dropped and flagged.
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_BRICKS  = 40,
  parameter int LIVES       = 3,
  parameter int SERVE_DELAY = 60,
  parameter int ROW_W       = 3,
  parameter int COL_W       = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          frame_clk,
  input  logic                          Reset_n,
  input  logic [7:0]                    key,
  input  logic                          ball_lost,
  input  logic                          brick_hit,
  input  logic [ROW_W-1:0]              hit_row,
  input  logic [COL_W-1:0]              hit_col,
  input  logic                          clr_ready,
  output logic                          clr_valid,
  output logic [ROW_W-1:0]              clr_row,
  output logic [COL_W-1:0]              clr_col,
  output logic                          map_reload,
  output logic                          ball_hold,
  output logic                          serve,
  output logic [$clog2(LIVES+1)-1:0]    lives_left,
  output logic [$clog2(NUM_BRICKS+1)-1:0] bricks_left,
  output game_state_t                   state,
  output logic                          win,
  output logic                          lose,
  output logic                          hit_overflow
);
  localparam int LW    = $clog2(LIVES+1);
  localparam int BW    = $clog2(NUM_BRICKS+1);
  localparam int CW    = $clog2(SERVE_DELAY+1);
  localparam int FIFOW = ROW_W + COL_W;

  game_state_t state_q, state_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [BW-1:0] bricks_q, bricks_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic serve_q, serve_d;
  logic reload_q, reload_d;
  logic hold_q, hold_d;
  logic win_q, win_d;
  logic lose_q, lose_d;

  logic restart, start, in_play, hit_acc;
  logic fifo_full, fifo_empty;
  logic [FIFOW-1:0] head_dat;

  assign restart = (key == KEY_RESTART);
  assign start   = (key == KEY_START);
  assign in_play = (state_q == PLAY);
  assign hit_acc = in_play && brick_hit && !fifo_full && !restart;

  brick_clear_fifo #(
    .WIDTH (FIFOW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (frame_clk),
    .rst_n    (Reset_n),
    .push     (hit_acc),
    .push_dat ({hit_row, hit_col}),
    .pop      (clr_ready),
    .flush    (restart),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat)
  );

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    bricks_d = bricks_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    serve_d  = 1'b0;
    reload_d = 1'b0;
    if (restart) begin
      state_d  = IDLE;
      lives_d  = LW'(LIVES);
      bricks_d = BW'(NUM_BRICKS);
      cnt_d    = '0;
      ovf_d    = 1'b0;
      reload_d = 1'b1;
    end else begin
      if (hit_acc && (bricks_q != '0)) begin
        bricks_d = bricks_q - 1'b1;
      end
      if (in_play && brick_hit && fifo_full) begin
        ovf_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = PLAY;
            serve_d = 1'b1;
          end
        end
        PLAY: begin
          // Clearing the last brick beats a same-frame ball loss.
          if (hit_acc && (bricks_q <= BW'(1))) begin
            state_d = WIN;
          end else if (ball_lost && (lives_q == LW'(1))) begin
            state_d = LOSE;
            lives_d = '0;
          end else if (ball_lost) begin
            state_d = DELAY;
            lives_d = lives_q - 1'b1;
            cnt_d   = CW'(SERVE_DELAY - 1);
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    hold_d = (state_d != PLAY);
    win_d  = (state_d == WIN);
    lose_d = (state_d == LOSE);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      lives_q  <= LW'(LIVES);
      bricks_q <= BW'(NUM_BRICKS);
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      serve_q  <= 1'b0;
      reload_q <= 1'b0;
      hold_q   <= 1'b1;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      bricks_q <= bricks_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      serve_q  <= serve_d;
      reload_q <= reload_d;
      hold_q   <= hold_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  assign state        = state_q;
  assign lives_left   = lives_q;
  assign bricks_left  = bricks_q;
  assign hit_overflow = ovf_q;
  assign serve        = serve_q;
  assign map_reload   = reload_q;
  assign ball_hold    = hold_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign clr_valid    = !fifo_empty;
  assign clr_row      = head_dat[FIFOW-1:COL_W];
  assign clr_col      = head_dat[COL_W-1:0];

endmodule
